// File: rtl/fetch_unit.sv
// Instruction fetch FSM: one outstanding memory request, decode handshake, flush/drain.
// Define FETCH_MISALIGN_TRAP_EN to halt on misaligned PCs; otherwise PC bits [1:0] are masked.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pcplus4,
   input  logic        i_instr_ready,
   input  logic        i_pcsrc,
   input  logic [31:0] i_pctarget,
   input  logic        i_flush,
   input  logic [31:0] i_flush_pc,
   output logic [31:0] o_retired,
   output logic        o_misaligned
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_VALID = 3'd2,
      S_DRAIN = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_retired;
   logic        w_accept;
   logic        w_capture;
   logic        w_pc_load;
   logic        w_trap;
   logic [31:0] w_pc_raw;
   logic [31:0] w_pc_new;

   // Flush outranks both the decode accept and a same-cycle memory response.
   assign w_accept  = (r_state == S_VALID) && i_instr_ready && !i_flush;
   assign w_capture = (r_state == S_FETCH) && i_imem_rvalid && !i_flush;
   assign w_pc_load = w_accept || i_flush;
   assign w_pc_raw  = i_flush ? i_flush_pc : (i_pcsrc ? i_pctarget : (r_pc + 32'd4));

`ifdef FETCH_MISALIGN_TRAP_EN
   logic r_misaligned;

   assign w_pc_new     = w_pc_raw;
   assign w_trap       = w_pc_load && (w_pc_raw[1:0] != 2'b00);
   assign o_misaligned = r_misaligned;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_misaligned <= 1'b0;
      end else begin
         r_misaligned <= (w_next_state == S_HALT);
      end
   end
`else
   assign w_pc_new     = w_pc_raw & 32'hFFFF_FFFC;
   assign w_trap       = 1'b0;
   assign o_misaligned = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            w_next_state = w_trap ? S_HALT : S_FETCH;
         end
         S_FETCH: begin
            // A flush without the response leaves one reply in flight that DRAIN must swallow.
            if (i_flush) begin
               if (w_trap) begin
                  w_next_state = S_HALT;
               end else if (i_imem_rvalid) begin
                  w_next_state = S_FETCH;
               end else begin
                  w_next_state = S_DRAIN;
               end
            end else if (i_imem_rvalid) begin
               w_next_state = S_VALID;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_VALID: begin
            if (w_pc_load) begin
               w_next_state = w_trap ? S_HALT : S_FETCH;
            end else begin
               w_next_state = S_VALID;
            end
         end
         S_DRAIN: begin
            if (w_trap) begin
               w_next_state = S_HALT;
            end else if (i_imem_rvalid) begin
               w_next_state = S_FETCH;
            end else begin
               w_next_state = S_DRAIN;
            end
         end
         S_HALT: begin
            if (i_flush && !w_trap) begin
               w_next_state = S_FETCH;
            end else begin
               w_next_state = S_HALT;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_comb begin
      o_imem_req    = 1'b0;
      o_instr_valid = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_imem_req    = 1'b1;
            o_instr_valid = 1'b0;
         end
         S_VALID: begin
            o_imem_req    = 1'b0;
            o_instr_valid = 1'b1;
         end
         default: begin
            o_imem_req    = 1'b0;
            o_instr_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc      <= RESET_PC;
         r_instr   <= NOP;
         r_retired <= 32'd0;
      end else begin
         if (w_pc_load) begin
            r_pc <= w_pc_new;
         end
         if (w_capture) begin
            r_instr <= i_imem_rdata;
         end
         if (w_accept) begin
            r_retired <= r_retired + 32'd1;
         end
      end
   end

   assign o_imem_addr = r_pc;
   assign o_instr     = r_instr;
   assign o_pc        = r_pc;
   assign o_pcplus4   = r_pc + 32'd4;
   assign o_retired   = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a PC/retire-count reference model and an address-hashed memory.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        i_clk;
   logic        i_rst;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        o_instr_valid;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic [31:0] o_pcplus4;
   logic        i_instr_ready;
   logic        i_pcsrc;
   logic [31:0] i_pctarget;
   logic        i_flush;
   logic [31:0] i_flush_pc;
   logic [31:0] o_retired;
   logic        o_misaligned;

   int checks   = 0;
   int failures = 0;

   bit          pend;
   int          cnt;
   logic [31:0] paddr;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
      .o_instr_valid(o_instr_valid), .o_instr(o_instr),
      .o_pc(o_pc), .o_pcplus4(o_pcplus4),
      .i_instr_ready(i_instr_ready), .i_pcsrc(i_pcsrc), .i_pctarget(i_pctarget),
      .i_flush(i_flush), .i_flush_pc(i_flush_pc),
      .o_retired(o_retired), .o_misaligned(o_misaligned)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Distinct word per aligned address (odd multiplier is a bijection mod 2^32).
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // Memory responder: called once per cycle at the falling edge.
   task automatic mem_resp(input int lat);
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = $urandom;
      if (pend) begin
         cnt = cnt - 1;
         if (cnt <= 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(paddr);
            pend = 1'b0;
         end
      end else if (o_imem_req) begin
         pend  = 1'b1;
         paddr = o_imem_addr;
         cnt   = lat;
      end
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      i_imem_rvalid = 1'b0; i_instr_ready = 1'b0; i_pcsrc = 1'b0;
      i_pctarget = 32'd0; i_flush = 1'b0; i_flush_pc = 32'd0;
      pend = 1'b0; cnt = 0;
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      checks++; if (o_imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", o_imem_req); end
      checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_instr_valid); end
      checks++; if (o_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", o_instr, NOP); end
      checks++; if (o_pc !== RST_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", o_pc, RST_PC); end
      checks++; if (o_pcplus4 !== RST_PC + 32'd4) begin failures++; $display("FAIL reset_pcplus4 got=%h", o_pcplus4); end
      checks++; if (o_retired !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", o_retired); end
      checks++; if (o_misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b exp=0", o_misaligned); end
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin
         failures++; $display("FAIL first_fetch req=%b addr=%h exp req=1 addr=%h", o_imem_req, o_imem_addr, RST_PC);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] addrs[$];
      int vcyc[$];
      int acc = 0;
      do_reset();
      i_instr_ready = 1'b1;
      for (int c = 0; c < 40 && acc < 3; c++) begin
         @(negedge i_clk);
         if (o_imem_req && !pend) addrs.push_back(o_imem_addr);
         if (o_instr_valid) begin acc++; vcyc.push_back(c); end
         mem_resp(1);
      end
      checks++; if (acc != 3) begin failures++; $display("FAIL seq_timeout accepts=%0d exp=3", acc); end
      @(negedge i_clk);
      checks++; if (o_retired !== 32'd3) begin failures++; $display("FAIL seq_retired got=%0d exp=3", o_retired); end
      if (addrs.size() >= 3) begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (addrs[k] !== 32'(4 * k)) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", k, addrs[k], 32'(4 * k)); end
         end
      end else begin
         checks++; failures++; $display("FAIL seq_addr_count got=%0d exp=3", addrs.size());
      end
      if (vcyc.size() == 3) begin
         checks++;
         if (vcyc[2] - vcyc[1] != 3) begin failures++; $display("FAIL seq_spacing got=%0d exp=3", vcyc[2] - vcyc[1]); end
      end
      i_instr_ready = 1'b0;
   endtask

   task automatic test_branch();
      bit found;
      logic [31:0] ret0;
      @(negedge i_clk);
      mem_resp(1);
      i_flush = 1'b1; i_flush_pc = 32'h10; i_instr_ready = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge i_clk);
         i_flush = 1'b0;
         mem_resp(1);
         if (o_instr_valid) found = 1'b1;
      end
      checks++; if (!found || o_pc !== 32'h10 || o_instr !== mem_word(32'h10)) begin
         failures++; $display("FAIL br_first found=%b pc=%h instr=%h exp pc=10", found, o_pc, o_instr);
      end
      ret0 = o_retired;
      i_instr_ready = 1'b1; i_pcsrc = 1'b1; i_pctarget = 32'h40;
      @(negedge i_clk);
      i_instr_ready = 1'b0; i_pcsrc = 1'b0;
      checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h40) begin
         failures++; $display("FAIL br_addr req=%b addr=%h exp req=1 addr=40", o_imem_req, o_imem_addr);
      end
      mem_resp(1);
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge i_clk);
         if (o_instr_valid) found = 1'b1;
         else mem_resp(1);
      end
      checks++; if (!found || o_pc !== 32'h40 || o_pcplus4 !== 32'h44 || o_retired !== ret0 + 32'd1) begin
         failures++; $display("FAIL br_target found=%b pc=%h pc4=%h ret=%0d exp pc=40 ret=%0d", found, o_pc, o_pcplus4, o_retired, ret0 + 32'd1);
      end
   endtask

   task automatic test_flush_fetch();
      do_reset();
      @(negedge i_clk);
      i_flush = 1'b1; i_flush_pc = 32'h80;
      for (int k = 1; k <= 3; k++) begin
         @(negedge i_clk);
         i_flush = 1'b0;
         checks++; if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin
            failures++; $display("FAIL drain_idle%0d req=%b valid=%b exp 0/0", k, o_imem_req, o_instr_valid);
         end
         if (k == 3) begin i_imem_rvalid = 1'b1; i_imem_rdata = mem_word(32'h0); end
      end
      @(negedge i_clk);
      i_imem_rvalid = 1'b0;
      checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h80 || o_instr_valid !== 1'b0 || o_retired !== 32'd0) begin
         failures++; $display("FAIL flush_refetch req=%b addr=%h valid=%b ret=%0d exp 1/80/0/0", o_imem_req, o_imem_addr, o_instr_valid, o_retired);
      end
      @(negedge i_clk);
      i_imem_rvalid = 1'b1; i_imem_rdata = mem_word(32'h80);
      @(negedge i_clk);
      i_imem_rvalid = 1'b0;
      checks++; if (o_instr_valid !== 1'b1 || o_pc !== 32'h80 || o_instr !== mem_word(32'h80)) begin
         failures++; $display("FAIL flush_word valid=%b pc=%h instr=%h exp pc=80 instr=%h", o_instr_valid, o_pc, o_instr, mem_word(32'h80));
      end
   endtask

   task automatic test_flush_same_cycle();
      do_reset();
      @(negedge i_clk);
      @(negedge i_clk);
      i_imem_rvalid = 1'b1; i_imem_rdata = mem_word(32'h0);
      i_flush = 1'b1; i_flush_pc = 32'h200;
      @(negedge i_clk);
      i_imem_rvalid = 1'b0; i_flush = 1'b0;
      checks++; if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h200 || o_instr !== NOP) begin
         failures++; $display("FAIL same_cycle valid=%b req=%b addr=%h instr=%h exp 0/1/200/NOP", o_instr_valid, o_imem_req, o_imem_addr, o_instr);
      end
   endtask

   task automatic test_reset_midfetch();
      do_reset();
      @(negedge i_clk);
      i_flush = 1'b1; i_flush_pc = 32'h300;
      @(negedge i_clk);
      i_flush = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      checks++; if (o_imem_req !== 1'b0 || o_pc !== RST_PC) begin
         failures++; $display("FAIL rst_async req=%b pc=%h exp 0/%h", o_imem_req, o_pc, RST_PC);
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
      @(negedge i_clk);
      i_imem_rvalid = 1'b0;
      checks++; if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== RST_PC || o_instr !== NOP) begin
         failures++; $display("FAIL stale_rvalid valid=%b req=%b addr=%h instr=%h", o_instr_valid, o_imem_req, o_imem_addr, o_instr);
      end
      @(negedge i_clk);
      i_imem_rvalid = 1'b1; i_imem_rdata = mem_word(RST_PC);
      @(negedge i_clk);
      i_imem_rvalid = 1'b0;
      checks++; if (o_instr_valid !== 1'b1 || o_pc !== RST_PC || o_instr !== mem_word(RST_PC)) begin
         failures++; $display("FAIL rst_first valid=%b pc=%h instr=%h", o_instr_valid, o_pc, o_instr);
      end
      i_instr_ready = 1'b1;
      @(negedge i_clk);
      i_instr_ready = 1'b0;
      checks++; if (o_retired !== 32'd1) begin failures++; $display("FAIL rst_retired got=%0d exp=1", o_retired); end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] exp_ret;
      int accepts = 0;
      int errs = 0;
      do_reset();
      exp_pc = RST_PC; exp_ret = 32'd0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge i_clk);
         checks++;
         if (o_retired !== exp_ret) begin
            failures++; errs++;
            if (errs < 10) $display("FAIL rnd_retired cyc=%0d got=%0d exp=%0d", c, o_retired, exp_ret);
         end else if (o_imem_req && o_imem_addr !== exp_pc) begin
            failures++; errs++;
            if (errs < 10) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, o_imem_addr, exp_pc);
         end else if (o_instr_valid && (o_pc !== exp_pc || o_instr !== mem_word(exp_pc) || o_pcplus4 !== exp_pc + 32'd4)) begin
            failures++; errs++;
            if (errs < 10) $display("FAIL rnd_instr cyc=%0d pc=%h instr=%h exp pc=%h instr=%h", c, o_pc, o_instr, exp_pc, mem_word(exp_pc));
         end else if ((o_instr_valid && o_imem_req) || o_misaligned) begin
            failures++; errs++;
            if (errs < 10) $display("FAIL rnd_flags cyc=%0d valid=%b req=%b mis=%b", c, o_instr_valid, o_imem_req, o_misaligned);
         end
         mem_resp(int'($urandom_range(1, 4)));
         i_instr_ready = 1'($urandom_range(0, 1));
         i_pcsrc       = 1'($urandom_range(0, 1));
         i_pctarget    = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
         i_flush       = ($urandom_range(0, 11) == 0);
         i_flush_pc    = $urandom & 32'hFFFF_FFFC;
         if (i_flush) begin
            exp_pc = i_flush_pc;
         end else if (o_instr_valid && i_instr_ready) begin
            exp_pc  = i_pcsrc ? i_pctarget : exp_pc + 32'd4;
            exp_ret = exp_ret + 32'd1;
            accepts++;
         end
      end
      i_flush = 1'b0; i_instr_ready = 1'b0;
      checks++; if (accepts < 20) begin failures++; $display("FAIL rnd_progress accepts=%0d exp>=20", accepts); end
   endtask

   task automatic test_misalign();
      bit found = 1'b0;
      do_reset();
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge i_clk);
         if (o_instr_valid) found = 1'b1;
         else mem_resp(1);
      end
      i_instr_ready = 1'b1; i_pcsrc = 1'b1; i_pctarget = 32'h42;
      @(negedge i_clk);
      i_instr_ready = 1'b0; i_pcsrc = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      checks++; if (!found || o_misaligned !== 1'b1 || o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin
         failures++; $display("FAIL mis_halt found=%b mis=%b req=%b valid=%b exp 1/0/0", found, o_misaligned, o_imem_req, o_instr_valid);
      end
      @(negedge i_clk);
      @(negedge i_clk);
      checks++; if (o_misaligned !== 1'b1 || o_imem_req !== 1'b0) begin
         failures++; $display("FAIL mis_hold mis=%b req=%b exp 1/0", o_misaligned, o_imem_req);
      end
      i_flush = 1'b1; i_flush_pc = 32'h100;
      @(negedge i_clk);
      i_flush = 1'b0;
      checks++; if (o_misaligned !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin
         failures++; $display("FAIL mis_resume mis=%b req=%b addr=%h exp 0/1/100", o_misaligned, o_imem_req, o_imem_addr);
      end
`else
      checks++; if (!found || o_misaligned !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h40) begin
         failures++; $display("FAIL mis_mask found=%b mis=%b req=%b addr=%h exp 0/1/40", found, o_misaligned, o_imem_req, o_imem_addr);
      end
`endif
   endtask

   initial begin
      i_rst = 1'b1;
      i_imem_rvalid = 1'b0; i_imem_rdata = 32'd0; i_instr_ready = 1'b0;
      i_pcsrc = 1'b0; i_pctarget = 32'd0; i_flush = 1'b0; i_flush_pc = 32'd0;
      pend = 1'b0; cnt = 0; paddr = 32'd0;
      test_reset();
      test_sequential();
      test_branch();
      test_flush_fetch();
      test_flush_same_cycle();
      test_reset_midfetch();
      test_random();
      test_misalign();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first instruction address after reset.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port o_imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port o_imem_addr  output  32  fetch address, equals current PC.
REQ-006 SHALL have port i_imem_rvalid  input  1  memory response valid, single-cycle pulse.
REQ-007 SHALL have port i_imem_rdata  input  32  instruction word, meaningful only with i_imem_rvalid.
REQ-008 SHALL have port o_instr_valid  output  1  instruction presented to decode/controller.
REQ-009 SHALL have port o_instr  output  32  held instruction; op, funct3 and funct7b5 fields feed the controller.
REQ-010 SHALL have port o_pc / o_pcplus4  output  32 each  address of o_instr and that address +4.
REQ-011 SHALL have port i_instr_ready  input  1  decode accepts o_instr this cycle.
REQ-012 SHALL have port i_pcsrc / i_pctarget  input  1 / 32  branch-or-jump taken and its target, sampled on accept.
REQ-013 SHALL have port i_flush / i_flush_pc  input  1 / 32  redirect and discard, with new PC.
REQ-014 SHALL have port o_retired  output  32  count of accepted instructions.
REQ-015 SHALL have port o_misaligned  output  1  misaligned-PC halt flag.

Function
REQ-016 SHALL implement states IDLE, FETCH, VALID, DRAIN, HALT; one memory request outstanding at most.
REQ-017 IDLE: o_imem_req=0; SHALL go to FETCH unconditionally next cycle; i_imem_rvalid ignored.
REQ-018 FETCH: o_imem_req=1, o_imem_addr=PC held stable until i_imem_rvalid; on i_imem_rvalid SHALL capture i_imem_rdata into o_instr and go to VALID; response latency >=1 cycle, unbounded.
REQ-019 VALID: o_instr_valid=1, o_instr/o_pc stable; on i_instr_ready SHALL set PC to i_pctarget if i_pcsrc else PC+4, increment o_retired, go to FETCH; minimum accept-to-accept spacing 3 cycles (VALID, FETCH, response).
REQ-020 o_instr_valid SHALL be 1 only in VALID; o_pcplus4 = o_pc+4 combinationally.
REQ-021 PC+4 and o_retired SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-022 i_flush SHALL have priority over i_instr_ready and i_imem_rvalid in the same cycle; PC <= i_flush_pc, o_retired unchanged.
REQ-023 i_flush in FETCH without same-cycle rvalid SHALL go to DRAIN; with same-cycle rvalid the word SHALL be dropped and state go to FETCH.
REQ-024 DRAIN: o_imem_req=0; SHALL drop the next i_imem_rvalid then go to FETCH; further i_flush in DRAIN only updates PC.
REQ-025 i_flush in IDLE or VALID SHALL go to FETCH with the new PC; i_flush in HALT per REQ-029.

Reset
REQ-026 On i_rst SHALL immediately force: state IDLE, PC=RESET_PC, o_instr=32'h0000_0013 (NOP), o_retired=0, o_misaligned=0, o_imem_req=0, o_instr_valid=0.
REQ-027 Reset mid-request SHALL abandon the request; a stale i_imem_rvalid arriving in IDLE SHALL be ignored.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN SHALL select misaligned-PC handling.
REQ-029 Defined: any new PC with bits [1:0]!=0 (branch target or flush PC) SHALL enter HALT: o_misaligned=1, o_imem_req=0, o_instr_valid=0; only i_flush with aligned i_flush_pc (-> FETCH, o_misaligned=0) or reset exits.
REQ-030 Not defined: PC bits [1:0] SHALL be forced to 0 on every PC update, HALT unreachable, o_misaligned tied 0.

Verification
REQ-031 Reset, memory responds 1 cycle after each request, ready held 1 -> addresses 0x0,0x4,0x8; o_retired=3 after third accept.
REQ-032 In VALID at PC=0x10, i_pcsrc=1, i_pctarget=0x40, ready=1 -> next o_imem_addr=0x40, o_pc=0x40 on next valid.
REQ-033 Flush to 0x80 in FETCH, rvalid 3 cycles later -> that word dropped, next request addr 0x80, o_retired unchanged.
REQ-034 Flush and rvalid same cycle in FETCH -> word dropped, o_instr_valid stays 0, FETCH at flush PC next cycle.
REQ-035 Reset asserted while in FETCH, stale rvalid one cycle after release -> ignored; first accepted o_pc=RESET_PC.
REQ-036 With FETCH_MISALIGN_TRAP_EN: target 0x42 taken -> o_misaligned=1, o_imem_req=0; flush to 0x100 -> resumes at 0x100; without macro fetch address 0x40.
